// File: rtl/pio_bus_master_if.sv
// PIO bus master interface: CPU request/response side,
// board pin side and interrupt line of one bus master.
interface pio_bus_master_if;
    logic        req;
    logic        we;
    logic [12:0] addr;
    logic [25:0] wdata;
    logic        busy;
    logic        ack;
    logic [25:0] rdata;
    logic [12:0] I;
    logic [25:0] db_out;
    logic        db_oe;
    logic [25:0] db_in;
    logic        nIOR;
    logic        nIOW;
    logic        int_in;
    logic        int_clr;
    logic        int_pending;

    modport master (
        input  req, we, addr, wdata, db_in,
        input  int_in, int_clr,
        output busy, ack, rdata,
        output I, db_out, db_oe, nIOR, nIOW,
        output int_pending
    );

    modport slave (
        output req, we, addr, wdata, db_in,
        output int_in, int_clr,
        input  busy, ack, rdata,
        input  I, db_out, db_oe, nIOR, nIOW,
        input  int_pending
    );
endinterface

// File: rtl/pio_bus_master.sv
// PIO bus master: single-word nIOR/nIOW strobe cycles on the
// 13-bit address / 26-bit data I/O bus, plus interrupt sync.
module pio_bus_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input logic              clk,
    input logic              rst,
    pio_bus_master_if.master bus
);

    localparam int MAX_A =
        (SETUP_CYCLES > STROBE_CYCLES) ?
        SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_P =
        (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CW = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] T_LD = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0] H_LD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic        we_q, we_n;
    logic [12:0] i_q, i_n;
    logic [25:0] dout_q, dout_n;
    logic        oe_q, oe_n;
    logic        nior_q, nior_n;
    logic        niow_q, niow_n;
    logic        busy_q, busy_n;
    logic        ack_q, ack_n;
    logic [25:0] rdata_q, rdata_n;

    logic        sync1, sync2, sync3;
    logic        int_rise;
    logic        pend_q;

    // Next state and next values of every registered output.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = we_q;
        i_n     = i_q;
        dout_n  = dout_q;
        oe_n    = oe_q;
        nior_n  = nior_q;
        niow_n  = niow_q;
        busy_n  = busy_q;
        ack_n   = 1'b0;
        rdata_n = rdata_q;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    state_n = SETUP;
                    cnt_n   = S_LD;
                    we_n    = bus.we;
                    i_n     = bus.addr;
                    busy_n  = 1'b1;
                    if (bus.we) begin
                        dout_n = bus.wdata;
                        oe_n   = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt == ONE) begin
                    state_n = STROBE;
                    cnt_n   = T_LD;
                    if (we_q) niow_n = 1'b0;
                    else      nior_n = 1'b0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            STROBE: begin
                if (cnt == ONE) begin
                    state_n = HOLD;
                    cnt_n   = H_LD;
                    nior_n  = 1'b1;
                    niow_n  = 1'b1;
                    if (!we_q) rdata_n = bus.db_in;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            HOLD: begin
                if (cnt == ONE) begin
                    state_n = DONE;
                    ack_n   = 1'b1;
                    oe_n    = 1'b0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            i_q     <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            nior_q  <= 1'b1;
            niow_q  <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            we_q    <= we_n;
            i_q     <= i_n;
            dout_q  <= dout_n;
            oe_q    <= oe_n;
            nior_q  <= nior_n;
            niow_q  <= niow_n;
            busy_q  <= busy_n;
            ack_q   <= ack_n;
            rdata_q <= rdata_n;
        end
    end

    // Two-flop synchroniser plus one flop of history for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.int_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign int_rise = sync2 & ~sync3;

    // Sticky pending flag; a new edge beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else if (int_rise) begin
            pend_q <= 1'b1;
        end else if (bus.int_clr) begin
            pend_q <= 1'b0;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.I           = i_q;
    assign bus.db_out      = dout_q;
    assign bus.db_oe       = oe_q;
    assign bus.nIOR        = nior_q;
    assign bus.nIOW        = niow_q;
    assign bus.int_pending = pend_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// Bench for pio_bus_master: default-timing and 1/1/1 instances
// against a cycle-count model, plus directed interrupt tests.
module tb_pio_bus_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pio_bus_master_if bus0();
    pio_bus_master_if bus1();

    logic        req_v   [2];
    logic        we_v    [2];
    logic [12:0] addr_v  [2];
    logic [25:0] wdata_v [2];
    logic [25:0] dbin_v  [2];
    logic        int_in;
    logic        int_clr;

    assign bus0.req     = req_v[0];
    assign bus0.we      = we_v[0];
    assign bus0.addr    = addr_v[0];
    assign bus0.wdata   = wdata_v[0];
    assign bus0.db_in   = dbin_v[0];
    assign bus0.int_in  = int_in;
    assign bus0.int_clr = int_clr;
    assign bus1.req     = req_v[1];
    assign bus1.we      = we_v[1];
    assign bus1.addr    = addr_v[1];
    assign bus1.wdata   = wdata_v[1];
    assign bus1.db_in   = dbin_v[1];
    assign bus1.int_in  = 1'b0;
    assign bus1.int_clr = 1'b0;

    logic        busy_o [2];
    logic        ack_o  [2];
    logic        oe_o   [2];
    logic        nior_o [2];
    logic        niow_o [2];
    logic [12:0] i_o    [2];
    logic [25:0] dout_o [2];
    logic [25:0] rd_o   [2];

    assign busy_o[0] = bus0.busy;
    assign ack_o[0]  = bus0.ack;
    assign oe_o[0]   = bus0.db_oe;
    assign nior_o[0] = bus0.nIOR;
    assign niow_o[0] = bus0.nIOW;
    assign i_o[0]    = bus0.I;
    assign dout_o[0] = bus0.db_out;
    assign rd_o[0]   = bus0.rdata;
    assign busy_o[1] = bus1.busy;
    assign ack_o[1]  = bus1.ack;
    assign oe_o[1]   = bus1.db_oe;
    assign nior_o[1] = bus1.nIOR;
    assign niow_o[1] = bus1.nIOW;
    assign i_o[1]    = bus1.I;
    assign dout_o[1] = bus1.db_out;
    assign rd_o[1]   = bus1.rdata;

    pio_bus_master u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    pio_bus_master #(
        .SETUP_CYCLES  (1),
        .STROBE_CYCLES (1),
        .HOLD_CYCLES   (1)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input int i, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h t=%0t",
                     i, nm, act, exp, $time);
        end
    endtask

    function automatic int ps(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int pt(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int ph(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int pn(input int i);
        return ps(i) + pt(i) + ph(i) + 1;
    endfunction

    // Model: m_t = cycles since the accepting edge, 0 when idle.
    int          m_t  [2];
    logic        m_w  [2];
    logic [12:0] m_a  [2];
    logic [25:0] m_d  [2];
    logic [25:0] m_rd [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_t[i]  <= 0;
                m_w[i]  <= 1'b0;
                m_a[i]  <= '0;
                m_d[i]  <= '0;
                m_rd[i] <= '0;
            end else if (m_t[i] == 0) begin
                if (req_v[i]) begin
                    m_t[i] <= 1;
                    m_w[i] <= we_v[i];
                    m_a[i] <= addr_v[i];
                    if (we_v[i]) m_d[i] <= wdata_v[i];
                end
            end else begin
                if (m_t[i] == ps(i) + pt(i) && !m_w[i])
                    m_rd[i] <= dbin_v[i];
                m_t[i] <= (m_t[i] == pn(i)) ? 0 : m_t[i] + 1;
            end
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk(i, "busy", busy_o[i], m_t[i] != 0);
            chk(i, "ack", ack_o[i], m_t[i] == pn(i));
            chk(i, "I", i_o[i], m_a[i]);
            chk(i, "db_oe", oe_o[i],
                m_w[i] && m_t[i] >= 1 &&
                m_t[i] <= ps(i) + pt(i) + ph(i));
            chk(i, "nIOW", niow_o[i],
                !(m_w[i] && m_t[i] > ps(i) &&
                  m_t[i] <= ps(i) + pt(i)));
            chk(i, "nIOR", nior_o[i],
                !(!m_w[i] && m_t[i] > ps(i) &&
                  m_t[i] <= ps(i) + pt(i)));
            chk(i, "one_strobe", nior_o[i] | niow_o[i], 1);
            chk(i, "rdata", rd_o[i], m_rd[i]);
            if (m_w[i] && m_t[i] >= 1 &&
                m_t[i] <= ps(i) + pt(i) + ph(i))
                chk(i, "db_out", dout_o[i], m_d[i]);
        end
        chk(1, "int_pending", bus1.int_pending, 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input int i, input logic w,
                         input logic [12:0] a,
                         input logic [25:0] d);
        tick();
        req_v[i]   = 1'b1;
        we_v[i]    = w;
        addr_v[i]  = a;
        wdata_v[i] = d;
        tick();
        req_v[i] = 1'b0;
    endtask

    // Observe n cycles after an accept (cycle 1 follows it).
    task automatic obs(input int i, input int n,
                       input int cut, input logic [25:0] late,
                       output int ack_at, output int oe_n,
                       output int w_n, output int w_first,
                       output int r_n, output logic [25:0] rd_ack);
        ack_at = 0; oe_n = 0; w_n = 0;
        w_first = 0; r_n = 0; rd_ack = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (ack_o[i] && ack_at == 0) begin
                ack_at = c;
                rd_ack = rd_o[i];
            end
            if (oe_o[i]) oe_n++;
            if (!niow_o[i]) begin
                w_n++;
                if (w_first == 0) w_first = c;
            end
            if (!nior_o[i]) r_n++;
            if (c == cut) dbin_v[i] = late;
        end
    endtask

    int a1, a2, oen, wn, wf, rn, k_seen;
    logic [25:0] rda;

    initial begin
        rst = 1'b1;
        int_in = 1'b0;
        int_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0;
            we_v[i] = 1'b0;
            addr_v[i] = '0;
            wdata_v[i] = '0;
            dbin_v[i] = '0;
        end
        #23;
        rst = 1'b0;
        chk(0, "reset_rdata", rd_o[0], 0);
        chk(0, "reset_nIOW", niow_o[0], 1);
        chk(0, "reset_pending", bus0.int_pending, 0);

        // Write with default timing.
        start(0, 1'b1, 13'h0A5, 26'h2AAAAAA);
        obs(0, 12, 0, '0, a1, oen, wn, wf, rn, rda);
        chk(0, "wr_ack_edge", a1, 9);
        chk(0, "wr_oe_cycles", oen, 8);
        chk(0, "wr_nIOW_cycles", wn, 4);
        chk(0, "wr_nIOW_start", wf, 3);
        chk(0, "wr_nIOR_cycles", rn, 0);

        // Read with default timing; db_in changes after strobe.
        dbin_v[0] = 26'h1555555;
        start(0, 1'b0, 13'h1FFF, 26'h0);
        obs(0, 12, 7, 26'h0000000, a1, oen, wn, wf, rn, rda);
        chk(0, "rd_ack_edge", a1, 9);
        chk(0, "rd_oe_cycles", oen, 0);
        chk(0, "rd_nIOR_cycles", rn, 4);
        chk(0, "rd_data_ack", rda, 26'h1555555);
        tick();
        tick();
        chk(0, "rd_data_held", rd_o[0], 26'h1555555);

        // Back-to-back: req held across write then read.
        tick();
        req_v[0] = 1'b1;
        we_v[0] = 1'b1;
        addr_v[0] = 13'h001;
        wdata_v[0] = 26'h0ABCDEF;
        tick();
        we_v[0] = 1'b0;
        addr_v[0] = 13'h002;
        a1 = 0;
        a2 = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (ack_o[0]) begin
                if (a1 == 0) a1 = c;
                else if (a2 == 0) a2 = c;
            end
            if (c == 10) chk(0, "b2b_I_done", i_o[0], 13'h001);
            if (c == 11) begin
                chk(0, "b2b_I_next", i_o[0], 13'h002);
                req_v[0] = 1'b0;
            end
        end
        chk(0, "b2b_ack1", a1, 9);
        chk(0, "b2b_spacing", a2 - a1, 10);

        // Reset during the 2nd strobe cycle of a write.
        start(0, 1'b1, 13'h0F0, 26'h1234567);
        tick();
        tick();
        tick();
        chk(0, "pre_rst_nIOW", niow_o[0], 0);
        rst = 1'b1;
        #1;
        chk(0, "rst_nIOW", niow_o[0], 1);
        chk(0, "rst_db_oe", oe_o[0], 0);
        chk(0, "rst_busy", busy_o[0], 0);
        chk(0, "rst_ack", ack_o[0], 0);
        #1;
        rst = 1'b0;
        start(0, 1'b1, 13'h0F1, 26'h3000001);
        obs(0, 12, 0, '0, a1, oen, wn, wf, rn, rda);
        chk(0, "post_rst_ack", a1, 9);
        chk(0, "post_rst_nIOW", wn, 4);

        // 1/1/1 instance: write then read.
        start(1, 1'b1, 13'h123, 26'h3FFFFFF);
        obs(1, 6, 0, '0, a1, oen, wn, wf, rn, rda);
        chk(1, "f_wr_ack", a1, 4);
        chk(1, "f_wr_nIOW", wn, 1);
        chk(1, "f_wr_start", wf, 2);
        chk(1, "f_wr_oe", oen, 3);
        dbin_v[1] = 26'h0ABCDEF;
        start(1, 1'b0, 13'h124, 26'h0);
        obs(1, 6, 3, 26'h0, a1, oen, wn, wf, rn, rda);
        chk(1, "f_rd_ack", a1, 4);
        chk(1, "f_rd_nIOR", rn, 1);
        chk(1, "f_rd_data", rda, 26'h0ABCDEF);

        // Interrupt: clear held high while the edge arrives.
        tick();
        int_in = 1'b1;
        int_clr = 1'b1;
        k_seen = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (bus0.int_pending && k_seen == 0) begin
                k_seen = k;
                int_clr = 1'b0;
            end
        end
        chk(0, "int_latency_ok", k_seen >= 2 && k_seen <= 3, 1);
        chk(0, "int_set_wins", bus0.int_pending, 1);
        tick();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk(0, "int_cleared", bus0.int_pending, 0);
        repeat (4) tick();
        chk(0, "int_level_no_reset", bus0.int_pending, 0);
        int_in = 1'b0;
        repeat (4) tick();
        int_in = 1'b1;
        repeat (4) tick();
        chk(0, "int_second_edge", bus0.int_pending, 1);

        // Random traffic on both instances.
        repeat (1500) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                req_v[i]   = ($urandom_range(0, 3) != 0);
                we_v[i]    = 1'($urandom_range(0, 1));
                addr_v[i]  = 13'($urandom);
                wdata_v[i] = 26'($urandom);
                dbin_v[i]  = 26'($urandom);
            end
        end
        for (int i = 0; i < 2; i++) req_v[i] = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
